// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 write-only register peripheral.
// Samples asynchronous sclk/copi/ncs through synchronisers, assembles
// 16-bit MSB-first frames and commits valid writes into five 8-bit
// control registers consumed by the PWM block.

module spi_reg_peripheral #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe
);

  localparam logic [6:0] MAX_ADDR_C = 7'(MAX_ADDR);
  localparam logic [4:0] CNT_FULL   = 5'd16;
  localparam logic [4:0] CNT_OVER   = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // A frame is committed only when exactly 16 bits arrived, it is a write
  // and the address falls inside the implemented register range.
  function automatic logic frame_valid(input logic [15:0] frame, input logic [4:0] count);
    return (count == CNT_FULL) && frame[15] && (frame[14:8] <= MAX_ADDR_C);
  endfunction

  // sclk and ncs carry one extra history flop for edge detection;
  // copi only needs the synchroniser depth.
  logic [SYNC_STAGES:0]   sclk_chain_r;
  logic [SYNC_STAGES:0]   ncs_chain_r;
  logic [SYNC_STAGES-1:0] copi_chain_r;

  logic sclk_s;
  logic sclk_prev_s;
  logic ncs_s;
  logic ncs_prev_s;
  logic copi_s;
  logic sclk_rise_s;
  logic ncs_fall_s;
  logic ncs_rise_s;

  state_t     state_r;
  state_t     state_next_s;
  logic [15:0] shift_r;
  logic [4:0]  cnt_r;

  logic clear_s;
  logic shift_en_s;
  logic commit_s;

  logic [7:0] reg0_r;
  logic [7:0] reg1_r;
  logic [7:0] reg2_r;
  logic [7:0] reg3_r;
  logic [7:0] reg4_r;
  logic       wr_strobe_r;

  // Synchronise the SPI pins into the clk domain; idle levels on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_chain_r <= {(SYNC_STAGES+1){1'b0}};
      ncs_chain_r  <= {(SYNC_STAGES+1){1'b1}};
      copi_chain_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sclk_chain_r <= {sclk_chain_r[SYNC_STAGES-1:0], sclk};
      ncs_chain_r  <= {ncs_chain_r[SYNC_STAGES-1:0], ncs};
      copi_chain_r <= {copi_chain_r[SYNC_STAGES-2:0], copi};
    end
  end

  assign sclk_s      = sclk_chain_r[SYNC_STAGES-1];
  assign sclk_prev_s = sclk_chain_r[SYNC_STAGES];
  assign ncs_s       = ncs_chain_r[SYNC_STAGES-1];
  assign ncs_prev_s  = ncs_chain_r[SYNC_STAGES];
  assign copi_s      = copi_chain_r[SYNC_STAGES-1];

  assign sclk_rise_s = sclk_s & ~sclk_prev_s;
  assign ncs_fall_s  = ~ncs_s & ncs_prev_s;
  assign ncs_rise_s  = ncs_s & ~ncs_prev_s;

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: a frame opens on ncs falling and closes on ncs rising.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ncs_fall_s) begin
          state_next_s = ST_SHIFT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (ncs_rise_s) begin
          state_next_s = ST_COMMIT;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_COMMIT: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Per-state control: clear at frame start, shift on sclk rise, decide commit.
  always_comb begin
    clear_s    = 1'b0;
    shift_en_s = 1'b0;
    commit_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        clear_s = ncs_fall_s;
      end
      ST_SHIFT: begin
        shift_en_s = sclk_rise_s & ~ncs_s;
      end
      ST_COMMIT: begin
        commit_s = frame_valid(shift_r, cnt_r);
      end
      default: begin
        commit_s = 1'b0;
      end
    endcase
  end

  // Shift register and saturating bit counter (17 marks an overlong frame).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= 16'h0000;
      cnt_r   <= 5'd0;
    end else if (clear_s) begin
      shift_r <= 16'h0000;
      cnt_r   <= 5'd0;
    end else if (shift_en_s) begin
      shift_r <= {shift_r[14:0], copi_s};
      if (cnt_r >= CNT_OVER) begin
        cnt_r <= CNT_OVER;
      end else begin
        cnt_r <= cnt_r + 5'd1;
      end
    end else begin
      shift_r <= shift_r;
      cnt_r   <= cnt_r;
    end
  end

  // Register file and write strobe, updated on the edge leaving COMMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg0_r      <= 8'h00;
      reg1_r      <= 8'h00;
      reg2_r      <= 8'h00;
      reg3_r      <= 8'h00;
      reg4_r      <= 8'h00;
      wr_strobe_r <= 1'b0;
    end else begin
      wr_strobe_r <= commit_s;
      if (commit_s) begin
        case (shift_r[14:8])
          7'd0:    reg0_r <= shift_r[7:0];
          7'd1:    reg1_r <= shift_r[7:0];
          7'd2:    reg2_r <= shift_r[7:0];
          7'd3:    reg3_r <= shift_r[7:0];
          7'd4:    reg4_r <= shift_r[7:0];
          default: reg0_r <= reg0_r;
        endcase
      end else begin
        reg0_r <= reg0_r;
      end
    end
  end

  assign en_reg_out_7_0  = reg0_r;
  assign en_reg_out_15_8 = reg1_r;
  assign en_reg_pwm_7_0  = reg2_r;
  assign en_reg_pwm_15_8 = reg3_r;
  assign pwm_duty_cycle  = reg4_r;
  assign wr_strobe       = wr_strobe_r;

endmodule
